// File: rtl/dp_sequencer_pkg.sv
// Shared definitions for the datapath instruction sequencer.
// Contents: instruction field widths, the packed instruction layout, the ALU32
// operation codes and the sequencer run/halt state encoding.
package dp_sequencer_pkg;

   localparam int unsigned INSTR_W = 10;
   localparam int unsigned OP_W    = 3;
   localparam int unsigned ADDR_W  = 2;

   // ALU32 operation encoding driven on ALUControl
   typedef enum logic [OP_W-1:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101,
      ALU_SLL = 3'b110,
      ALU_NOR = 3'b111
   } alu_op_e;

   // Instruction word: [9]=skz, [8:6]=op, [5:4]=addr1, [3:2]=addr2, [1:0]=addr3
   typedef struct packed {
      logic              skz;
      logic [OP_W-1:0]   op;
      logic [ADDR_W-1:0] addr1;
      logic [ADDR_W-1:0] addr2;
      logic [ADDR_W-1:0] addr3;
   } instr_t;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } seq_state_e;

endpackage

// File: rtl/dp_instr_fifo.sv
// Synchronous instruction FIFO with synchronous active-high reset.
// Ports: clk, rst; push/din write side (ignored when full); pop/dout read side
// (dout shows the head entry, pop ignored when empty); full, empty status.
module dp_instr_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = (count == DEPTH_CNT);
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; occupancy is tracked by count
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/dp_sequencer.sv
// Instruction sequencer for the 4x32 register-file + ALU32 datapath.
// Ports: clk, rst (sync, active-high); in_valid/in_instr/in_ready instruction
// intake; clear_fault leaves HALT; Zero/Overflow from the datapath for the
// instruction currently issued; ALUControl, addr1..3 (registered) and wr
// (combinational) to the datapath; busy, fault, retired, skipped status.
module dp_sequencer
   import dp_sequencer_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned CNT_W       = 16,
   parameter bit          TRAP_ON_OVF = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               in_ready,
   input  logic               clear_fault,
   input  logic               Zero,
   input  logic               Overflow,
   output logic [OP_W-1:0]    ALUControl,
   output logic [ADDR_W-1:0]  addr1,
   output logic [ADDR_W-1:0]  addr2,
   output logic [ADDR_W-1:0]  addr3,
   output logic               wr,
   output logic               busy,
   output logic               fault,
   output logic [CNT_W-1:0]   retired,
   output logic [CNT_W-1:0]   skipped
);

   seq_state_e         state;
   logic [INSTR_W-1:0] fifo_q;
   instr_t             head;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop;
   logic               issue_valid;
   logic               issue_skz;
   logic               skip_pending;
   logic               trap;

   dp_instr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (INSTR_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid),
      .din   (in_instr),
      .pop   (pop),
      .dout  (fifo_q),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign head = fifo_q;

   // A non-skipped issue that overflows is the trap event
   assign trap     = issue_valid & ~skip_pending & TRAP_ON_OVF & Overflow;
   assign wr       = issue_valid & ~skip_pending & ~(TRAP_ON_OVF & Overflow);
   // Trapping cycle holds the next instruction in the FIFO
   assign pop      = (state == ST_RUN) & ~fifo_empty & ~trap;
   assign in_ready = ~fifo_full;
   assign busy     = ~fifo_empty | issue_valid;
   assign fault    = (state == ST_HALT);

   // Issue register, skip tracking, counters and RUN/HALT state
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_RUN;
         issue_valid  <= 1'b0;
         issue_skz    <= 1'b0;
         skip_pending <= 1'b0;
         ALUControl   <= '0;
         addr1        <= '0;
         addr2        <= '0;
         addr3        <= '0;
         retired      <= '0;
         skipped      <= '0;
      end else begin
         issue_valid <= pop;
         if (pop) begin
            ALUControl <= head.op;
            addr1      <= head.addr1;
            addr2      <= head.addr2;
            addr3      <= head.addr3;
            issue_skz  <= head.skz;
         end

         if (wr) retired <= retired + CNT_W'(1);

         // The shadowed instruction consumes the skip; it cannot arm a new one
         if (issue_valid & skip_pending) begin
            skipped      <= skipped + CNT_W'(1);
            skip_pending <= 1'b0;
         end else if (wr & issue_skz & Zero) begin
            skip_pending <= 1'b1;
         end

         case (state)
            ST_RUN:  if (trap) state <= ST_HALT;
            ST_HALT: if (clear_fault) state <= ST_RUN;
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_dp_sequencer.sv
// Self-checking bench for dp_sequencer: a behavioural register file + ALU
// closes the loop on Zero/Overflow, an architectural reference model predicts
// commits and traps in program order, and a monitor scores every wr cycle.
module tb_dp_sequencer;
   import dp_sequencer_pkg::*;

   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic [9:0]       in_instr;
   logic             in_ready;
   logic             clear_fault;
   logic             Zero;
   logic             Overflow;
   logic [2:0]       ALUControl;
   logic [1:0]       addr1;
   logic [1:0]       addr2;
   logic [1:0]       addr3;
   logic             wr;
   logic             busy;
   logic             fault;
   logic [CNT_W-1:0] retired;
   logic [CNT_W-1:0] skipped;

   dp_sequencer #(
      .FIFO_DEPTH  (4),
      .CNT_W       (CNT_W),
      .TRAP_ON_OVF (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_instr    (in_instr),
      .in_ready    (in_ready),
      .clear_fault (clear_fault),
      .Zero        (Zero),
      .Overflow    (Overflow),
      .ALUControl  (ALUControl),
      .addr1       (addr1),
      .addr2       (addr2),
      .addr3       (addr3),
      .wr          (wr),
      .busy        (busy),
      .fault       (fault),
      .retired     (retired),
      .skipped     (skipped)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string name, input longint unsigned act,
                               input longint unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // ---------------- ALU semantics (shared by datapath and model) ----------
   typedef struct packed {
      logic [31:0] r;
      logic        ovf;
   } alu_t;

   function automatic alu_t alu(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b);
      alu_t o;
      o.ovf = 1'b0;
      o.r   = 32'd0;
      case (op)
         3'd0: begin o.r = a + b; o.ovf = (a[31] == b[31]) && (o.r[31] != a[31]); end
         3'd1: begin o.r = a - b; o.ovf = (a[31] != b[31]) && (o.r[31] != a[31]); end
         3'd2: o.r = a & b;
         3'd3: o.r = a | b;
         3'd4: o.r = a ^ b;
         3'd5: o.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd6: o.r = a << b[4:0];
         default: o.r = ~(a | b);
      endcase
      return o;
   endfunction

   // ---------------- behavioural datapath ----------------------------------
   logic [31:0] regs [4];
   logic        pre_en = 1'b0;
   logic [1:0]  pre_addr = 2'd0;
   logic [31:0] pre_val = 32'd0;
   alu_t        dp_out;

   always_comb dp_out = alu(ALUControl, regs[addr1], regs[addr2]);
   assign Overflow = dp_out.ovf;
   assign Zero     = (dp_out.r == 32'd0);

   always @(posedge clk) begin
      if (pre_en)  regs[pre_addr] <= pre_val;
      else if (wr) regs[addr3]    <= dp_out.r;
   end

   // ---------------- reference model + scoreboard --------------------------
   typedef struct {
      bit       trap;
      bit [2:0] op;
      bit [1:0] a1;
      bit [1:0] a2;
      bit [1:0] a3;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_regs [4];
   bit          m_skip = 1'b0;
   int unsigned m_retired = 0;
   int unsigned m_skipped = 0;

   // Architectural effect of one accepted instruction, in program order
   function automatic void model_issue(input logic [9:0] ins);
      exp_t e;
      alu_t o;
      e.trap = 1'b0;
      e.op = ins[8:6];
      e.a1 = ins[5:4];
      e.a2 = ins[3:2];
      e.a3 = ins[1:0];
      if (m_skip) begin
         m_skip = 1'b0;
         m_skipped++;
         return;
      end
      o = alu(e.op, ref_regs[e.a1], ref_regs[e.a2]);
      if (o.ovf) begin
         e.trap = 1'b1;
         sb.push_back(e);
         return;
      end
      ref_regs[e.a3] = o.r;
      m_retired++;
      sb.push_back(e);
      if (ins[9] && o.r == 32'd0) m_skip = 1'b1;
   endfunction

   int unsigned wr_stamps[$];

   // Monitor: every wr cycle and every HALT entry consumes one expectation
   initial begin : monitor
      bit   prev_fault;
      exp_t e;
      prev_fault = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_fault = 1'b0;
         end else begin
            if (wr) begin
               wr_stamps.push_back(cyc);
               if (sb.size() == 0) begin
                  chk("unexpected_wr", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("wr_not_trap", 64'(wr), 64'(!e.trap));
                  chk("issue_fields", {ALUControl, addr1, addr2, addr3},
                      {e.op, e.a1, e.a2, e.a3});
               end
            end
            if (fault && !prev_fault) begin
               if (sb.size() == 0) begin
                  chk("unexpected_trap", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("trap_expected", 64'(fault), 64'(e.trap));
               end
            end
            prev_fault = fault;
         end
      end
   end

   // ---------------- stimulus helpers --------------------------------------
   bit          auto_clear = 1'b0;
   int unsigned last_acc_cyc = 0;

   task automatic preset(input logic [1:0] a, input logic [31:0] v);
      pre_en = 1'b1; pre_addr = a; pre_val = v;
      ref_regs[a] = v;
      @(negedge clk);
      pre_en = 1'b0;
   endtask

   task automatic push(input logic [9:0] ins);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_instr = ins;
      while (!in_ready) begin
         clear_fault = auto_clear & fault;
         @(negedge clk);
         t++;
         if (t > 200) begin
            chk("push_timeout", 1, 0);
            in_valid = 1'b0; clear_fault = 1'b0;
            return;
         end
      end
      clear_fault = auto_clear & fault;
      last_acc_cyc = cyc;
      model_issue(ins);
      @(negedge clk);
      in_valid = 1'b0;
      clear_fault = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         clear_fault = auto_clear & fault;
         @(negedge clk);
      end
      clear_fault = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy || fault) begin
         clear_fault = auto_clear & fault;
         @(negedge clk);
         t++;
         if (t > 500) begin
            chk("idle_timeout", 1, 0);
            break;
         end
      end
      clear_fault = 1'b0;
   endtask

   task automatic wait_fault();
      int t;
      t = 0;
      while (!fault) begin
         @(negedge clk);
         t++;
         if (t > 50) begin
            chk("fault_timeout", 1, 0);
            break;
         end
      end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence -----------------------------------------
   initial begin : main
      logic [CNT_W-1:0] r0;
      logic [CNT_W-1:0] s0;
      int unsigned      base;
      logic [31:0]      snap [4];
      logic [9:0]       burst [5];

      rst = 1'b1; in_valid = 1'b0; in_instr = '0; clear_fault = 1'b0;

      // 1. reset
      @(negedge clk);
      @(negedge clk);
      chk("rst_wr", 64'(wr), 0);
      chk("rst_fault", 64'(fault), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_retired", 64'(retired), 0);
      chk("rst_skipped", 64'(skipped), 0);
      chk("rst_controls", {ALUControl, addr1, addr2, addr3}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 1);
      for (int i = 0; i < 4; i++) preset(2'(i), 32'd0);

      // 2. single add R0 = R1 + R2, two edges from acceptance to commit
      preset(2'd1, 32'd5);
      preset(2'd2, 32'd3);
      base = wr_stamps.size();
      push(10'h018);
      wait_idle();
      chk("add_wr_count", 64'(wr_stamps.size() - base), 1);
      if (wr_stamps.size() > base)
         chk("add_latency", 64'(wr_stamps[base] - last_acc_cyc), 2);
      chk("add_r0", 64'(regs[0]), 8);
      chk("add_retired", 64'(retired), 1);

      // 3. burst while held in HALT
      preset(2'd1, 32'h7FFF_FFFF);
      preset(2'd2, 32'd1);
      push(10'h018);
      wait_fault();
      preset(2'd1, 32'd1);
      preset(2'd2, 32'd2);
      burst[0] = 10'h098; burst[1] = 10'h0D9; burst[2] = 10'h11A;
      burst[3] = 10'h09B; burst[4] = 10'h1D8;
      r0 = retired;
      base = wr_stamps.size();
      for (int i = 0; i < 4; i++) push(burst[i]);
      chk("burst_full_ready", 64'(in_ready), 0);
      chk("burst_halted", 64'(fault), 1);
      auto_clear = 1'b1;
      push(burst[4]);
      auto_clear = 1'b0;
      wait_idle();
      chk("burst_wr_count", 64'(wr_stamps.size() - base), 5);
      if (wr_stamps.size() >= base + 4)
         chk("burst_back_to_back", 64'(wr_stamps[base+3] - wr_stamps[base]), 3);
      chk("burst_retired", 64'(retired - r0), 5);

      // 4. skip-if-zero; the shadowed add would overflow but must not trap
      preset(2'd0, 32'h55);
      preset(2'd1, 32'h7FFF_FFFF);
      preset(2'd2, 32'd1);
      preset(2'd3, 32'd0);
      r0 = retired; s0 = skipped;
      push(10'h23F);
      push(10'h018);
      wait_idle();
      chk("skip_r0", 64'(regs[0]), 64'h55);
      chk("skip_skipped", 64'(skipped - s0), 1);
      chk("skip_retired", 64'(retired - r0), 1);
      chk("skip_no_fault", 64'(fault), 0);

      // 5. overflow trap holds the following instruction
      preset(2'd0, 32'h55);
      r0 = retired;
      base = wr_stamps.size();
      push(10'h018);
      push(10'h01C);
      wait_fault();
      idle(3);
      chk("trap_r0", 64'(regs[0]), 64'h55);
      chk("trap_busy", 64'(busy), 1);
      chk("trap_fault", 64'(fault), 1);
      chk("trap_no_wr", 64'(wr_stamps.size() - base), 0);
      clear_fault = 1'b1;
      @(negedge clk);
      clear_fault = 1'b0;
      wait_idle();
      chk("trap_resume_r0", 64'(regs[0]), 64'h7FFF_FFFF);
      chk("trap_retired", 64'(retired - r0), 1);

      // 6. reset with three entries queued behind a trap
      preset(2'd1, 32'h7FFF_FFFF);
      preset(2'd2, 32'd1);
      push(10'h018);
      wait_fault();
      for (int i = 0; i < 4; i++) snap[i] = ref_regs[i];
      push(10'h098); push(10'h0D9); push(10'h11A);
      rst = 1'b1;
      sb.delete();
      m_skip = 1'b0; m_retired = 0; m_skipped = 0;
      for (int i = 0; i < 4; i++) ref_regs[i] = snap[i];
      @(negedge clk);
      rst = 1'b0;
      base = wr_stamps.size();
      chk("mid_rst_wr", 64'(wr), 0);
      chk("mid_rst_busy", 64'(busy), 0);
      chk("mid_rst_fault", 64'(fault), 0);
      chk("mid_rst_retired", 64'(retired), 0);
      chk("mid_rst_skipped", 64'(skipped), 0);
      idle(3);
      chk("mid_rst_no_wr", 64'(wr_stamps.size() - base), 0);
      push(10'h0D8);
      wait_idle();
      chk("post_rst_retired", 64'(retired), 1);
      chk("post_rst_r0", 64'(regs[0]), 64'(ref_regs[0]));

      // 7. randomized stream with automatic fault clearing
      auto_clear = 1'b1;
      for (int i = 0; i < 4; i++)
         preset(2'(i), ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom);
      for (int n = 0; n < 120; n++) begin
         logic [9:0] ins;
         ins = 10'($urandom);
         ins[9] = ($urandom_range(0, 2) == 0);
         push(ins);
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      wait_idle();
      auto_clear = 1'b0;
      chk("rand_sb_empty", 64'(sb.size()), 0);
      chk("rand_retired", 64'(retired), 64'(CNT_W'(m_retired)));
      chk("rand_skipped", 64'(skipped), 64'(CNT_W'(m_skipped)));
      for (int i = 0; i < 4; i++) chk("rand_reg", 64'(regs[i]), 64'(ref_regs[i]));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
